// File: rtl/alu1_monitor.sv
// Response checker for a 1-bit ALU: two-stage sample/compare pipeline with saturating
// counters, sticky first-error capture, 64-vector coverage bitmap and a verdict FSM.
module alu1_monitor #(
   parameter int unsigned CNT_W       = 16,
   parameter bit          CHECK_CARRY = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic             A,
   input  logic             B,
   input  logic             carryin,
   input  logic [2:0]       control,
   input  logic             out,
   input  logic             carryout,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] err_count,
   output logic             first_err_valid,
   output logic [5:0]       first_err_vec,
   output logic [1:0]       first_err_got,
   output logic             coverage_full,
   output logic             done,
   output logic             pass
);

   typedef enum logic [1:0] {StIdle, StRun, StPass, StFail} state_e;

   state_e           state_q, state_d;
   logic             s1_valid_q;
   logic [5:0]       s1_vec_q;
   logic [1:0]       s1_got_q;
   logic [CNT_W-1:0] vec_q, err_q;
   logic             fev_q;
   logic [5:0]       fevec_q;
   logic [1:0]       fegot_q;
   logic [63:0]      cov_q, cov_next;
   logic             bx, sum, cout, lgc, exp_out, mismatch, err_seen;

   // Stage 1: register the raw sample; a clear in the same cycle drops it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_vec_q   <= '0;
         s1_got_q   <= '0;
      end else begin
         s1_valid_q <= enable & ~clear;
         s1_vec_q   <= {control, carryin, B, A};
         s1_got_q   <= {carryout, out};
      end
   end

   // Golden model on the stage-1 sample; vector layout is {control,carryin,B,A}.
   always_comb begin
      bx   = s1_vec_q[1] ^ s1_vec_q[3];
      sum  = s1_vec_q[0] ^ bx ^ s1_vec_q[2];
      cout = (s1_vec_q[0] & bx) | (s1_vec_q[0] & s1_vec_q[2]) | (bx & s1_vec_q[2]);
      unique case (s1_vec_q[4:3])
         2'b00:   lgc = s1_vec_q[0] & s1_vec_q[1];
         2'b01:   lgc = s1_vec_q[0] | s1_vec_q[1];
         2'b10:   lgc = ~(s1_vec_q[0] | s1_vec_q[1]);
         default: lgc = s1_vec_q[0] ^ s1_vec_q[1];
      endcase
      exp_out  = s1_vec_q[5] ? lgc : sum;
      mismatch = s1_valid_q &
                 ((s1_got_q[0] != exp_out) | (CHECK_CARRY & (s1_got_q[1] != cout)));
      cov_next = cov_q | (64'd1 << s1_vec_q);
      err_seen = (err_q != '0) | mismatch;
   end

   // Stage 2: counters, first-error capture and coverage.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vec_q   <= '0;
         err_q   <= '0;
         fev_q   <= 1'b0;
         fevec_q <= '0;
         fegot_q <= '0;
         cov_q   <= '0;
      end else if (clear) begin
         vec_q   <= '0;
         err_q   <= '0;
         fev_q   <= 1'b0;
         fevec_q <= '0;
         fegot_q <= '0;
         cov_q   <= '0;
      end else if (s1_valid_q) begin
         if (vec_q != {CNT_W{1'b1}}) vec_q <= vec_q + CNT_W'(1'b1);
         if (mismatch && err_q != {CNT_W{1'b1}}) err_q <= err_q + CNT_W'(1'b1);
         if (mismatch && !fev_q) begin
            fev_q   <= 1'b1;
            fevec_q <= s1_vec_q;
            fegot_q <= s1_got_q;
         end
         cov_q <= cov_next;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)      state_q <= StIdle;
      else if (clear) state_q <= StIdle;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (s1_valid_q) begin
         unique case (state_q)
            StIdle:  state_d = StRun;
            StRun:   if (&cov_next) state_d = err_seen ? StFail : StPass;
            StPass:  if (mismatch) state_d = StFail;
            default: state_d = StFail;
         endcase
      end
   end

   always_comb begin
      vec_count       = vec_q;
      err_count       = err_q;
      first_err_valid = fev_q;
      first_err_vec   = fevec_q;
      first_err_got   = fegot_q;
      coverage_full   = &cov_q;
      done            = (state_q == StPass) | (state_q == StFail);
      pass            = (state_q == StPass);
   end

endmodule

// File: tb/tb_alu1_monitor.sv
// Bench for alu1_monitor: three instances (default, carry unchecked, 4-bit counters) share
// one stimulus stream and are checked every cycle against a transaction-level model.
module tb_alu1_monitor;

   logic       clock = 1'b0;
   logic       reset, clear, enable, A, B, carryin, out, carryout;
   logic [2:0] control;

   logic [15:0] vc0, ec0, vc1, ec1;
   logic [3:0]  vc2, ec2;
   logic        fv0, fv1, fv2, cf0, cf1, cf2, dn0, dn1, dn2, ps0, ps1, ps2;
   logic [5:0]  fx0, fx1, fx2;
   logic [1:0]  fg0, fg1, fg2;

   int nchecks = 0;
   int nerr    = 0;

   always #5 clock = ~clock;

   alu1_monitor #(.CNT_W(16), .CHECK_CARRY(1'b1)) u_main (
      .clock(clock), .reset(reset), .clear(clear), .enable(enable), .A(A), .B(B),
      .carryin(carryin), .control(control), .out(out), .carryout(carryout),
      .vec_count(vc0), .err_count(ec0), .first_err_valid(fv0), .first_err_vec(fx0),
      .first_err_got(fg0), .coverage_full(cf0), .done(dn0), .pass(ps0));

   alu1_monitor #(.CNT_W(16), .CHECK_CARRY(1'b0)) u_nc (
      .clock(clock), .reset(reset), .clear(clear), .enable(enable), .A(A), .B(B),
      .carryin(carryin), .control(control), .out(out), .carryout(carryout),
      .vec_count(vc1), .err_count(ec1), .first_err_valid(fv1), .first_err_vec(fx1),
      .first_err_got(fg1), .coverage_full(cf1), .done(dn1), .pass(ps1));

   alu1_monitor #(.CNT_W(4), .CHECK_CARRY(1'b1)) u_w4 (
      .clock(clock), .reset(reset), .clear(clear), .enable(enable), .A(A), .B(B),
      .carryin(carryin), .control(control), .out(out), .carryout(carryout),
      .vec_count(vc2), .err_count(ec2), .first_err_valid(fv2), .first_err_vec(fx2),
      .first_err_got(fg2), .coverage_full(cf2), .done(dn2), .pass(ps2));

   // Reference ALU: returns {carryout,out}; vec = {control,carryin,B,A}.
   function automatic logic [1:0] alu_ref(input logic [5:0] vec);
      int   a, b, cin, s;
      logic lg;
      a   = int'(vec[0]);
      b   = int'(vec[1]);
      cin = int'(vec[2]);
      s   = a + (vec[3] ? 1 - b : b) + cin;
      case (vec[4:3])
         2'd0:    lg = (a == 1 && b == 1);
         2'd1:    lg = (a == 1 || b == 1);
         2'd2:    lg = (a == 0 && b == 0);
         default: lg = (a != b);
      endcase
      return {logic'(s >= 2), vec[5] ? lg : logic'(s % 2)};
   endfunction

   // Model state per instance; mst: 0 idle, 1 run, 2 pass, 3 fail.
   int          maxc [3] = '{65535, 65535, 15};
   bit          chk  [3] = '{1'b1, 1'b0, 1'b1};
   int          mvec [3], merr [3], mst [3];
   bit          mfv  [3];
   logic [5:0]  mfvec[3];
   logic [1:0]  mfgot[3];
   bit   [63:0] mcov [3];
   bit          pend_v = 1'b0;
   logic [5:0]  pend_vec;
   logic [1:0]  pend_got;

   task automatic model_clear();
      for (int i = 0; i < 3; i++) begin
         mvec[i] = 0; merr[i] = 0; mst[i] = 0; mfv[i] = 0;
         mfvec[i] = '0; mfgot[i] = '0; mcov[i] = '0;
      end
      pend_v = 1'b0;
   endtask

   task automatic model_apply();
      logic [1:0] e;
      bit         bad;
      e = alu_ref(pend_vec);
      for (int i = 0; i < 3; i++) begin
         bad = (pend_got[0] != e[0]) || (chk[i] && pend_got[1] != e[1]);
         mvec[i]++;
         if (bad) begin
            merr[i]++;
            if (!mfv[i]) begin mfv[i] = 1; mfvec[i] = pend_vec; mfgot[i] = pend_got; end
         end
         mcov[i][pend_vec] = 1'b1;
         if (mst[i] == 0) mst[i] = 1;
         else if (mst[i] == 1 && mcov[i] == '1) mst[i] = (merr[i] != 0) ? 3 : 2;
         else if (mst[i] == 2 && bad) mst[i] = 3;
      end
   endtask

   always @(posedge clock) begin
      if (reset || clear) model_clear();
      else begin
         if (pend_v) model_apply();
         pend_v   = enable;
         pend_vec = {control, carryin, B, A};
         pend_got = {carryout, out};
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      nchecks++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got %0h want %0h", name, got, exp);
      end
   endtask

   task automatic cmp(input int i, input logic [15:0] vc, input logic [15:0] ec,
                      input logic fv, input logic [5:0] fx, input logic [1:0] fg,
                      input logic cf, input logic dn, input logic ps);
      check($sformatf("vec_count[%0d]", i), 64'(vc), 64'(mvec[i] > maxc[i] ? maxc[i] : mvec[i]));
      check($sformatf("err_count[%0d]", i), 64'(ec), 64'(merr[i] > maxc[i] ? maxc[i] : merr[i]));
      check($sformatf("first_err_valid[%0d]", i), 64'(fv), 64'(mfv[i]));
      check($sformatf("first_err_vec[%0d]", i), 64'(fx), 64'(mfvec[i]));
      check($sformatf("first_err_got[%0d]", i), 64'(fg), 64'(mfgot[i]));
      check($sformatf("coverage_full[%0d]", i), 64'(cf), 64'(mcov[i] == '1));
      check($sformatf("done[%0d]", i), 64'(dn), 64'(mst[i] >= 2));
      check($sformatf("pass[%0d]", i), 64'(ps), 64'(mst[i] == 2));
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         cmp(0, vc0, ec0, fv0, fx0, fg0, cf0, dn0, ps0);
         cmp(1, vc1, ec1, fv1, fx1, fg1, cf1, dn1, ps1);
         cmp(2, {12'd0, vc2}, {12'd0, ec2}, fv2, fx2, fg2, cf2, dn2, ps2);
      end
   end

   task automatic sample(input logic [5:0] vec, input bit bad_out, input bit bad_cout);
      logic [1:0] e;
      e = alu_ref(vec);
      {control, carryin, B, A} = vec;
      out      = e[0] ^ bad_out;
      carryout = e[1] ^ bad_cout;
      enable   = 1'b1;
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      enable = 1'b0;
      repeat (n) @(negedge clock);
   endtask

   task automatic do_clear();
      enable = 1'b0;
      clear  = 1'b1;
      @(negedge clock);
      clear  = 1'b0;
   endtask

   // mode 0 correct, 1 corrupt out at control=4 A=B=1, 2 corrupt carryout everywhere
   task automatic run_all(input int mode);
      logic [5:0] v;
      for (int k = 0; k < 64; k++) begin
         v = 6'(k);
         sample(v, mode == 1 && v[5:3] == 3'd4 && v[1:0] == 2'b11, mode == 2);
      end
      idle(2);
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; enable = 1'b0;
      A = 0; B = 0; carryin = 0; control = '0; out = 0; carryout = 0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("reset_vec_count", 64'(vc0), 64'd0);
      check("reset_done", 64'(dn0), 64'd0);

      run_all(0);
      check("t1_vec_count", 64'(vc0), 64'd64);
      check("t1_err_count", 64'(ec0), 64'd0);
      check("t1_coverage", 64'(cf0), 64'd1);
      check("t1_pass", 64'({dn0, ps0}), 64'b11);

      do_clear();
      run_all(1);
      check("t2_err_count", 64'(ec0), 64'd2);
      check("t2_first_vec", 64'(fx0), 64'b100011);
      check("t2_first_got", 64'(fg0), 64'b10);
      check("t2_done_pass", 64'({dn0, ps0}), 64'b10);

      do_clear();
      run_all(2);
      check("t3_nc_err_count", 64'(ec1), 64'd0);
      check("t3_err_count", 64'(ec0), 64'd64);
      check("t3_first_vec", 64'(fx0), 64'd0);
      check("t3_w4_err_sat", 64'(ec2), 64'd15);

      do_clear();
      for (int k = 0; k < 20; k++) sample(6'(k * 3), 1'b0, 1'b0);
      idle(2);
      check("t4_w4_vec_sat", 64'(vc2), 64'd15);
      check("t4_vec_count", 64'(vc0), 64'd20);

      do_clear();
      for (int k = 0; k < 10; k++) sample(6'(k + 40), 1'b0, k == 4);
      check("t5_vec_before", 64'(vc0), 64'd9);
      sample(6'd7, 1'b1, 1'b0);
      enable = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("t5_reset_vec", 64'(vc0), 64'd0);
      check("t5_reset_err", 64'(ec0), 64'd0);
      check("t5_reset_fev", 64'(fv0), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      idle(2);
      check("t5_inflight_dropped", 64'(vc0), 64'd0);
      check("t5_idle_state", 64'({dn0, ps0}), 64'd0);

      for (int k = 0; k < 3; k++) sample(6'(k), 1'b0, 1'b0);
      idle(2);
      sample(6'd9, 1'b0, 1'b0);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      check("t6_clear_after_sample", 64'(vc0), 64'd0);
      {control, carryin, B, A} = 6'd5;
      enable = 1'b1;
      clear  = 1'b1;
      @(negedge clock);
      clear  = 1'b0;
      enable = 1'b0;
      check("t6_clear_with_enable", 64'(vc0), 64'd0);
      idle(2);
      check("t6_sample_dropped", 64'(vc0), 64'd0);

      $display("CHECKS %0d ERRORS %0d", nchecks, nerr);
      $finish;
   end

endmodule
